// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, FSM states, default latencies.
// Optional accumulate ops are enabled with MDU_MADD_EN.
package mdu_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_MULT  = 4'h1;
   localparam logic [3:0] OP_MULTU = 4'h2;
   localparam logic [3:0] OP_DIV   = 4'h3;
   localparam logic [3:0] OP_DIVU  = 4'h4;
   localparam logic [3:0] OP_MTHI  = 4'h5;
   localparam logic [3:0] OP_MTLO  = 4'h6;
   localparam logic [3:0] OP_MADD  = 4'h7;
   localparam logic [3:0] OP_MADDU = 4'h8;
   localparam logic [3:0] OP_MSUB  = 4'h9;
   localparam logic [3:0] OP_MSUBU = 4'hA;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } mdu_state_e;

   // Multiply-class ops share the MULT_CYCLES latency.
   function automatic logic is_mul(input logic [3:0] op);
      logic r;
      r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
      r = r || (op == OP_MADD) || (op == OP_MADDU) ||
          (op == OP_MSUB) || (op == OP_MSUBU);
`endif
      return r;
   endfunction

   function automatic logic is_long(input logic [3:0] op);
      return is_mul(op) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational {HI,LO} result for every MDU op; NOP codes return acc.
// Accumulate ops are compiled in only with MDU_MADD_EN.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
   input  logic [63:0] acc,
   output logic [63:0] res
);

   logic signed [63:0] smul;
   logic [63:0]        umul;
   logic signed [31:0] sq;
   logic signed [31:0] sr;
   logic [31:0]        uq;
   logic [31:0]        ur;
   logic               b_zero;
   logic               s_ovf;

   assign smul   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign umul   = {32'b0, a} * {32'b0, b};
   assign sq     = $signed(a) / $signed(b);
   assign sr     = $signed(a) % $signed(b);
   assign uq     = a / b;
   assign ur     = a % b;
   assign b_zero = (b == 32'h0);
   assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

   always_comb begin
      res = acc;
      case (op)
         OP_MULT:  res = $unsigned(smul);
         OP_MULTU: res = umul;
         OP_DIV: begin
            if (b_zero)     res = {a, 32'hFFFF_FFFF};
            else if (s_ovf) res = {32'h0, 32'h8000_0000};
            else            res = {$unsigned(sr), $unsigned(sq)};
         end
         OP_DIVU: begin
            if (b_zero) res = {a, 32'hFFFF_FFFF};
            else        res = {ur, uq};
         end
         OP_MTHI: res = {a, acc[31:0]};
         OP_MTLO: res = {acc[63:32], a};
`ifdef MDU_MADD_EN
         OP_MADD:  res = acc + $unsigned(smul);
         OP_MADDU: res = acc + umul;
         OP_MSUB:  res = acc - $unsigned(smul);
         OP_MSUBU: res = acc - umul;
`endif
         default: res = acc;
      endcase
   end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers (EX stage).
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  MDUOp,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAXN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

   mdu_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0] pend_q, pend_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [63:0] res;

   mdu_arith u_arith (
      .a   (A),
      .b   (B),
      .op  (MDUOp),
      .acc ({hi_q, lo_q}),
      .res (res)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               if (is_long(MDUOp)) begin
                  pend_d  = res;
                  cnt_d   = is_mul(MDUOp) ? CW'(MULT_CYCLES - 1)
                                          : CW'(DIV_CYCLES - 1);
                  state_d = S_RUN;
               end else begin
                  // NOP codes yield res == {HI,LO}, so this is a no-op.
                  {hi_d, lo_d} = res;
               end
            end
         end
         S_RUN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               {hi_d, lo_d} = pend_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign Busy = (state_q == S_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random ops vs a model.
// Honours MDU_MADD_EN the same way as the design.
module tb_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [3:0]  MDUOp = '0;
   logic        Start = 1'b0;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .B     (B),
      .MDUOp (MDUOp),
      .Start (Start),
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit madd_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return op >= 4'd7 && op <= 4'd10;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int lat(input logic [3:0] op);
      if (op == 4'd1 || op == 4'd2 || madd_op(op)) return MC;
      if (op == 4'd3 || op == 4'd4) return DC;
      return 0;
   endfunction

   // Reference: plain integer arithmetic on 64-bit {HI,LO}.
   function automatic logic [63:0] model(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic [63:0] hl);
      longint sp;
      logic [63:0] up;
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      sp = longint'(sa) * longint'(sb);
      up = 64'(a) * 64'(b);
      case (op)
         4'd1: return sp;
         4'd2: return up;
         4'd3: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return {32'h0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         4'd4: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         4'd5: return {a, hl[31:0]};
         4'd6: return {hl[63:32], a};
         default: begin
            if (!madd_op(op)) return hl;
            if (op == 4'd7) return hl + sp;
            if (op == 4'd8) return hl + up;
            if (op == 4'd9) return hl - sp;
            return hl - up;
         end
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue op; optionally fire an ignored DIV at cycle 2 of Busy.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
      logic [63:0] e;
      int n;
      e = model(op, a, b, {m_hi, m_lo});
      n = lat(op);
      A = a; B = b; MDUOp = op; Start = 1'b1;
      tick();
      Start = 1'b0; MDUOp = 4'd0;
      for (int k = 0; k < n; k++) begin
         chk("busy_run", {31'b0, Busy}, 32'd1);
         chk("hi_hold", HI, m_hi);
         chk("lo_hold", LO, m_lo);
         if (poke && k == 2) begin
            A = $urandom; B = $urandom; MDUOp = 4'd3; Start = 1'b1;
         end else begin
            Start = 1'b0; MDUOp = 4'd0;
         end
         tick();
      end
      Start = 1'b0;
      chk("busy_done", {31'b0, Busy}, 32'd0);
      chk("hi", HI, e[63:32]);
      chk("lo", LO, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
   endtask

   initial begin
      logic [3:0] op;
      logic [31:0] ra, rb;
      #2;
      chk("rst_busy", {31'b0, Busy}, 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      run_op(4'd1, 32'hFFFF_FFFF, 32'h2, 1'b0);
      chk("mult_hi", HI, 32'hFFFF_FFFF);
      chk("mult_lo", LO, 32'hFFFF_FFFE);
      run_op(4'd2, 32'hFFFF_FFFF, 32'h2, 1'b0);
      chk("multu_hi", HI, 32'h1);
      chk("multu_lo", LO, 32'hFFFF_FFFE);
      run_op(4'd3, 32'hFFFF_FFF9, 32'h2, 1'b0);
      chk("div_hi", HI, 32'hFFFF_FFFF);
      chk("div_lo", LO, 32'hFFFF_FFFD);
      run_op(4'd4, 32'h7, 32'h0, 1'b0);
      chk("divu0_hi", HI, 32'h7);
      chk("divu0_lo", LO, 32'hFFFF_FFFF);
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("ovf_hi", HI, 32'h0);
      chk("ovf_lo", LO, 32'h8000_0000);

      run_op(4'd5, 32'h1234_5678, 32'h0, 1'b0);
      run_op(4'd6, 32'h9ABC_DEF0, 32'h0, 1'b0);
      chk("mthi", HI, 32'h1234_5678);
      chk("mtlo", LO, 32'h9ABC_DEF0);

      // Ignored DIV mid-MULT, then DIV right after Busy falls.
      run_op(4'd1, 32'd1234, 32'hFFFF_FFF0, 1'b1);
      run_op(4'd3, 32'd100, 32'd7, 1'b0);
      chk("b2b_lo", LO, 32'd14);
      chk("b2b_hi", HI, 32'd2);

      // Reset mid-run discards the pending result.
      A = 32'hDEAD_BEEF; B = 32'h55; MDUOp = 4'd1; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("arst_busy", {31'b0, Busy}, 32'd0);
      chk("arst_hi", HI, 32'd0);
      chk("arst_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      m_hi = '0; m_lo = '0;
      for (int i = 0; i < 12; i++) tick();
      chk("post_rst_busy", {31'b0, Busy}, 32'd0);
      chk("post_rst_hi", HI, 32'd0);
      chk("post_rst_lo", LO, 32'd0);

      run_op(4'd5, 32'h0, 32'h0, 1'b0);
      run_op(4'd6, 32'hFFFF_FFFF, 32'h0, 1'b0);
      run_op(4'd8, 32'h1, 32'h1, 1'b0);
`ifdef MDU_MADD_EN
      chk("maddu_hi", HI, 32'h1);
      chk("maddu_lo", LO, 32'h0);
`else
      chk("maddu_off_hi", HI, 32'h0);
      chk("maddu_off_lo", LO, 32'hFFFF_FFFF);
`endif

      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'h0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 9));
            default: ;
         endcase
         run_op(op, ra, rb, i[2]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, alongside the ALU.
- Consumes the same forwarded A/B operands as the ALU and holds results in architectural HI/LO registers.
- HI/LO feed the EX-stage result mux for mfhi/mflo.
- Busy/Start drive the hazard unit's stall logic.

Parameters:
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO update (>=1)
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update (>=1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- A  in  32  operand rs (forwarded)
- B  in  32  operand rt (forwarded)
- MDUOp  in  4  operation code; values in mdu_defs
- Start  in  1  one-cycle request qualifier for MDUOp
- Busy  out  1  registered; high while an operation is in flight
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Reset (async, active-low):
  - HI=0, LO=0, Busy=0, state=IDLE, counter=0.
  - Any in-flight operation is discarded with no partial HI/LO write.
  - Deassertion takes effect at the next clk edge.
- Op codes:
  - 0000 NOP
  - 0001 MULT
  - 0010 MULTU
  - 0011 DIV
  - 0100 DIVU
  - 0101 MTHI
  - 0110 MTLO
  - 0111–1010 reserved for the optional feature
  - All other codes are NOP.
- States: IDLE, RUN.
- IDLE, Start=1 with MULT/MULTU/DIV/DIVU at edge t0:
  - Latch A, B, op.
  - Compute the 64-bit result into the pending register (sub-module, combinational).
  - Load counter = N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - Busy=1; go to RUN.
- RUN, each edge:
  - counter != 0: decrement.
  - counter == 0: commit pending to HI/LO, Busy=0, go to IDLE.
  - HI/LO change at edge t0+N; Busy is high for exactly N cycles.
  - A, B and MDUOp are ignored while in RUN.
- MTHI/MTLO with Start=1 in IDLE: HI (resp. LO) = A at the same edge; Busy stays 0.
- Start=1 while Busy=1: ignored entirely, with no HI/LO write and no restart. The hazard unit must stall on (Start & mult/div) | Busy.
- Back-to-back: a new Start is accepted on the edge immediately after Busy falls.
- MULT: signed 32x32 gives a 64-bit product; HI = [63:32], LO = [31:0].
- MULTU: same split, unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU): LO = 32'hFFFFFFFF, HI = A.
- Signed overflow (A = 32'h80000000, B = 32'hFFFFFFFF): LO = 32'h80000000, HI = 0.
- HI/LO are readable combinationally every cycle; during RUN they hold the previous values.

Optional Feature:
- MDU_MADD_EN defined adds accumulate ops, committed after MULT_CYCLES with the same Busy rules:
  - 0111 MADD: {HI,LO} += signed A*B
  - 1000 MADDU: unsigned accumulate
  - 1001 MSUB: {HI,LO} -= signed A*B
  - 1010 MSUBU: unsigned subtract
  - Accumulation uses the {HI,LO} value present at the accept edge; 64-bit wrap-around, no saturation.
- MDU_MADD_EN undefined: codes 0111–1010 are NOP; Busy stays 0 and HI/LO are unchanged.

Decomposition:
- Shared header mdu_defs:
  - MDUOp code constants
  - state encodings (IDLE, RUN)
  - default cycle counts
- Sub-module mdu_arith: combinational, computes the 64-bit {HI,LO} result from A, B, op and the current {HI,LO}.
- mdu owns the FSM, counter and HI/LO registers.

Test Plan:
- MULT A=FFFFFFFF, B=00000002 -> Busy high for 5 cycles; then HI=FFFFFFFF, LO=FFFFFFFE. MULTU with the same operands -> HI=00000001, LO=FFFFFFFE.
- DIV A=FFFFFFF9 (-7), B=00000002 -> after 10 cycles LO=FFFFFFFD, HI=FFFFFFFF. DIVU A=7, B=0 -> LO=FFFFFFFF, HI=00000007. DIV 80000000 / FFFFFFFF -> LO=80000000, HI=0.
- MTHI A=12345678 then MTLO A=9ABCDEF0 on consecutive cycles -> HI/LO updated on each edge; Busy never asserts.
- MULT started; Start=1 with DIV at cycle 2 of Busy -> DIV ignored, MULT result committed on schedule. DIV issued the cycle after Busy falls -> accepted.
- MULT in flight; reset pulled low mid-run -> Busy=0 and HI=LO=0 immediately; no commit after release.
- With MDU_MADD_EN: HI=0, LO=FFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0. Without the macro, same stimulus -> no change, Busy=0.
